// File: rtl/bus_arbiter_pkg.sv
// Shared types and helpers for the N-master system bus arbiter.
package bus_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int TCNT_W = 8;

    // Index width for a master number; never narrower than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/bus_rr_picker.sv
// Combinational winner selection: optional absolute priority for master 0,
// otherwise round-robin scan starting just after the last round-robin winner.
module bus_rr_picker
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter bit PRIO0       = 1'b1,
    parameter int IW          = clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IW-1:0]          rr_last,
    output logic [IW-1:0]          win,
    output logic                   vld,
    output logic                   rr_win
);

    always_comb begin
        int          k;
        logic [IW-1:0] kk;
        k      = 0;
        kk     = '0;
        win    = '0;
        vld    = 1'b0;
        rr_win = 1'b0;
        if (PRIO0 && req[0]) begin
            vld = 1'b1;
        end else begin
            for (int i = 1; i <= NUM_MASTERS; i++) begin
                k  = (int'(rr_last) + i) % NUM_MASTERS;
                kk = IW'(k);
                if (!vld && req[kk] && !(PRIO0 && k == 0)) begin
                    vld    = 1'b1;
                    rr_win = 1'b1;
                    win    = kk;
                end
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_n.sv
// N-master arbiter for the shared memory bus: registered grant, combinational
// ack/data steering, abort on request drop and ack timeout for dead slaves.
module bus_arbiter_n
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter bit PRIO0       = 1'b1,
    parameter int TIMEOUT     = 15
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic [NUM_MASTERS-1:0]           i_m_cs,
    input  logic [NUM_MASTERS-1:0]           i_m_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] i_m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] i_m_dat,
    output logic [DATA_WIDTH-1:0]            o_m_dat,
    output logic [NUM_MASTERS-1:0]           o_m_ack,
    output logic [NUM_MASTERS-1:0]           o_m_err,
    output logic [ADDR_WIDTH-1:0]            o_addr,
    output logic [DATA_WIDTH-1:0]            o_dat,
    output logic                             o_we,
    output logic                             o_cs,
    input  logic [DATA_WIDTH-1:0]            i_dat,
    input  logic                             i_ack,
    output logic [NUM_MASTERS-1:0]           o_grant,
    output logic                             o_busy
);

    localparam int IW = clog2(NUM_MASTERS);

    state_t                 state;
    logic [IW-1:0]          g;
    logic [IW-1:0]          rr_last;
    logic [NUM_MASTERS-1:0] grant;
    logic [TCNT_W-1:0]      tcnt;

    logic [IW-1:0] pick;
    logic          pick_vld;
    logic          pick_rr;
    logic          busy;
    logic          cs_g;
    logic          ack_hit;
    logic          tout_hit;
    logic          done;

    bus_rr_picker #(
        .NUM_MASTERS(NUM_MASTERS),
        .PRIO0      (PRIO0),
        .IW         (IW)
    ) u_picker (
        .req    (i_m_cs),
        .rr_last(rr_last),
        .win    (pick),
        .vld    (pick_vld),
        .rr_win (pick_rr)
    );

    assign busy     = (state == BUSY);
    assign cs_g     = i_m_cs[g];
    assign ack_hit  = busy && i_ack;
    // A master that has already dropped its request is aborted, not timed out.
    assign tout_hit = busy && !i_ack && cs_g && (tcnt == TCNT_W'(TIMEOUT - 1));
    assign done     = ack_hit || tout_hit || (busy && !cs_g);

    always_comb begin
        o_m_ack = '0;
        o_m_err = '0;
        o_m_dat = '0;
        o_addr  = '0;
        o_dat   = '0;
        o_we    = 1'b0;
        o_cs    = 1'b0;
        if (busy) begin
            o_addr = i_m_addr[int'(g)*ADDR_WIDTH +: ADDR_WIDTH];
            o_dat  = i_m_dat[int'(g)*DATA_WIDTH +: DATA_WIDTH];
            o_we   = i_m_we[g];
            o_cs   = cs_g;
            if (ack_hit) begin
                o_m_ack[g] = 1'b1;
                o_m_dat    = i_dat;
            end else if (tout_hit) begin
                o_m_ack[g] = 1'b1;
                o_m_err[g] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= IDLE;
            g       <= '0;
            grant   <= '0;
            rr_last <= IW'(NUM_MASTERS - 1);
            tcnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state <= BUSY;
                        g     <= pick;
                        grant <= NUM_MASTERS'(1) << pick;
                        tcnt  <= '0;
                        if (pick_rr) rr_last <= pick;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state <= IDLE;
                        grant <= '0;
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_grant = grant;
    assign o_busy  = busy;

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Bench for bus_arbiter_n: cycle table, hand-built corner sequences, and a
// randomized run against a transaction-level reference model.
module tb_bus_arbiter_n;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 15;
    localparam bit P0 = 1'b1;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic [N-1:0]    m_cs, m_we;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_dat;
    logic [DW-1:0]   o_m_dat, o_dat, s_dat;
    logic [N-1:0]    o_m_ack, o_m_err, o_grant;
    logic [AW-1:0]   o_addr;
    logic            o_we, o_cs, s_ack, o_busy;

    bus_arbiter_n #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PRIO0(P0), .TIMEOUT(TO)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_m_cs(m_cs), .i_m_we(m_we), .i_m_addr(m_addr), .i_m_dat(m_dat),
        .o_m_dat(o_m_dat), .o_m_ack(o_m_ack), .o_m_err(o_m_err),
        .o_addr(o_addr), .o_dat(o_dat), .o_we(o_we), .o_cs(o_cs),
        .i_dat(s_dat), .i_ack(s_ack),
        .o_grant(o_grant), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [15:0] addr_of(input int k);
        return 16'h1000 + 16'(k) * 16'h0111;
    endfunction

    typedef struct {
        logic [N-1:0] cs;
        logic         ack;
        logic [7:0]   idat;
        logic [N-1:0] e_grant;
        logic         e_busy;
        logic         e_cs;
        logic [N-1:0] e_ack;
        logic [7:0]   e_mdat;
        logic [15:0]  e_addr;
    } vec_t;

    function automatic vec_t mk(input logic [N-1:0] cs, input logic ack,
                                input logic [7:0] idat, input logic [N-1:0] eg);
        vec_t v;
        int   idx;
        idx       = 0;
        v.cs      = cs;
        v.ack     = ack;
        v.idat    = idat;
        v.e_grant = eg;
        v.e_busy  = |eg;
        v.e_cs    = |(cs & eg);
        v.e_ack   = ack ? eg : '0;
        v.e_mdat  = (ack && |eg) ? idat : 8'h00;
        for (int k = 0; k < N; k++) if (eg[k]) idx = k;
        v.e_addr  = (|eg) ? addr_of(idx) : 16'h0000;
        return v;
    endfunction

    vec_t tbl[14];

    // Reference model state
    int owner, elapsed, rr_l;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1;
        m_cs = '0; m_we = '0; s_ack = 1'b0; s_dat = '0;
        for (int k = 0; k < N; k++) begin
            m_addr[k*AW +: AW] = addr_of(k);
            m_dat[k*DW +: DW]  = 8'(8'h30 + k);
        end
        #2;
        chk("rst_grant", o_grant, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_cs", o_cs, 0);
        chk("rst_ack", o_m_ack, 0);
        chk("rst_err", o_m_err, 0);
        chk("rst_addr", o_addr, 0);
        step();
        i_reset = 1'b0;

        // Priority then round-robin, zero-wait slave
        tbl[0]  = mk(3'b011, 1'b1, 8'h40, 3'b000);
        tbl[1]  = mk(3'b011, 1'b1, 8'h41, 3'b001);
        tbl[2]  = mk(3'b010, 1'b1, 8'h42, 3'b000);
        tbl[3]  = mk(3'b010, 1'b1, 8'h43, 3'b010);
        tbl[4]  = mk(3'b000, 1'b0, 8'h44, 3'b000);
        tbl[5]  = mk(3'b110, 1'b1, 8'h45, 3'b000);
        tbl[6]  = mk(3'b110, 1'b1, 8'h46, 3'b100);
        tbl[7]  = mk(3'b110, 1'b1, 8'h47, 3'b000);
        tbl[8]  = mk(3'b110, 1'b1, 8'h48, 3'b010);
        tbl[9]  = mk(3'b110, 1'b1, 8'h49, 3'b000);
        tbl[10] = mk(3'b110, 1'b1, 8'h4a, 3'b100);
        tbl[11] = mk(3'b110, 1'b1, 8'h4b, 3'b000);
        tbl[12] = mk(3'b110, 1'b1, 8'h4c, 3'b010);
        tbl[13] = mk(3'b000, 1'b0, 8'h4d, 3'b000);
        for (int i = 0; i < 14; i++) begin
            m_cs = tbl[i].cs; s_ack = tbl[i].ack; s_dat = tbl[i].idat;
            #3;
            chk($sformatf("tbl%0d_grant", i), o_grant, tbl[i].e_grant);
            chk($sformatf("tbl%0d_busy", i), o_busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_cs", i), o_cs, tbl[i].e_cs);
            chk($sformatf("tbl%0d_ack", i), o_m_ack, tbl[i].e_ack);
            chk($sformatf("tbl%0d_mdat", i), o_m_dat, tbl[i].e_mdat);
            chk($sformatf("tbl%0d_addr", i), o_addr, tbl[i].e_addr);
            step();
        end

        // Master 2 read with three wait states
        m_addr[2*AW +: AW] = 16'h1234;
        m_cs = 3'b100; s_ack = 1'b0; s_dat = 8'hA5;
        #3; chk("ws_idle_busy", o_busy, 0);
        step();
        for (int c = 1; c <= 4; c++) begin
            s_ack = (c == 4);
            #3;
            chk($sformatf("ws%0d_addr", c), o_addr, 16'h1234);
            chk($sformatf("ws%0d_cs", c), o_cs, 1);
            chk($sformatf("ws%0d_we", c), o_we, 0);
            chk($sformatf("ws%0d_grant", c), o_grant, 3'b100);
            chk($sformatf("ws%0d_ack", c), o_m_ack, (c == 4) ? 3'b100 : 3'b000);
            chk($sformatf("ws%0d_mdat", c), o_m_dat, (c == 4) ? 8'hA5 : 8'h00);
            step();
        end
        m_cs = '0; s_ack = 1'b0;
        #3; chk("ws_after_busy", o_busy, 0);
        step();

        // Master 1 with a dead slave
        m_cs = 3'b010; s_dat = 8'hFF;
        step();
        for (int c = 1; c <= TO; c++) begin
            #3;
            chk($sformatf("to%0d_ack", c), o_m_ack, (c == TO) ? 3'b010 : 3'b000);
            chk($sformatf("to%0d_err", c), o_m_err, (c == TO) ? 3'b010 : 3'b000);
            chk($sformatf("to%0d_busy", c), o_busy, 1);
            if (c == TO) chk("to_mdat", o_m_dat, 8'h00);
            step();
        end
        m_cs = '0;
        #3; chk("to_after_busy", o_busy, 0); chk("to_after_grant", o_grant, 0);
        step();

        // Master 1 aborts in its third BUSY cycle
        m_cs = 3'b010;
        step();
        for (int c = 1; c <= 2; c++) begin
            #3; chk($sformatf("ab%0d_cs", c), o_cs, 1);
            step();
        end
        m_cs = '0;
        #3;
        chk("ab_cs_low", o_cs, 0);
        chk("ab_no_ack", o_m_ack, 0);
        chk("ab_still_busy", o_busy, 1);
        step();
        #3; chk("ab_idle", o_busy, 0); chk("ab_idle_grant", o_grant, 0);
        step();

        // Ack arriving in the timeout cycle: ack only
        m_cs = 3'b100; s_dat = 8'h5A;
        step();
        for (int c = 1; c <= TO; c++) begin
            s_ack = (c == TO);
            #3;
            if (c == TO) begin
                chk("at_ack", o_m_ack, 3'b100);
                chk("at_err", o_m_err, 3'b000);
                chk("at_mdat", o_m_dat, 8'h5A);
            end else begin
                chk($sformatf("at%0d_ack", c), o_m_ack, 3'b000);
            end
            step();
        end
        m_cs = '0; s_ack = 1'b0;
        step();

        // Reset mid-transfer, then rr_last is back to NUM_MASTERS-1
        m_cs = 3'b010;
        step();
        step();
        #2; i_reset = 1'b1;
        #1;
        chk("mr_cs", o_cs, 0);
        chk("mr_grant", o_grant, 0);
        chk("mr_busy", o_busy, 0);
        chk("mr_ack", o_m_ack, 0);
        step();
        i_reset = 1'b0;
        m_cs = 3'b110; s_ack = 1'b1; s_dat = 8'h77;
        #3; chk("mr_idle", o_busy, 0);
        step();
        #3;
        chk("mr_grant1", o_grant, 3'b010);
        chk("mr_ack1", o_m_ack, 3'b010);
        step();
        m_cs = '0; s_ack = 1'b0;

        // Randomized traffic against the reference model
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        owner = -1; elapsed = 0; rr_l = N - 1;
        begin
            logic [N-1:0]  last_ack;
            logic [N-1:0]  e_ack, e_err, e_grant;
            logic [DW-1:0] e_mdat, e_dat;
            logic [AW-1:0] e_addr;
            logic          e_cs, e_we, fin;
            int            pct;
            last_ack = '0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                case ((cyc / 200) % 3)
                    0:       pct = 70;
                    1:       pct = 20;
                    default: pct = 3;
                endcase
                for (int k = 0; k < N; k++) begin
                    if (last_ack[k]) m_cs[k] = 1'b0;
                    else if (m_cs[k]) begin
                        if ($urandom_range(99) < 3) m_cs[k] = 1'b0;
                    end else if ($urandom_range(99) < 40) begin
                        m_cs[k] = 1'b1;
                        m_we[k] = 1'($urandom);
                        m_addr[k*AW +: AW] = 16'($urandom);
                        m_dat[k*DW +: DW]  = 8'($urandom);
                    end
                end
                s_ack = ($urandom_range(99) < pct);
                s_dat = 8'($urandom);

                e_ack = '0; e_err = '0; e_grant = '0; e_mdat = '0; e_dat = '0;
                e_addr = '0; e_cs = 1'b0; e_we = 1'b0; fin = 1'b0;
                if (owner >= 0) begin
                    e_grant = N'(1) << owner;
                    e_addr  = m_addr[owner*AW +: AW];
                    e_dat   = m_dat[owner*DW +: DW];
                    e_we    = m_we[owner];
                    e_cs    = m_cs[owner];
                    if (s_ack) begin
                        e_ack = e_grant; e_mdat = s_dat; fin = 1'b1;
                    end else if (!m_cs[owner]) begin
                        fin = 1'b1;
                    end else if (elapsed == TO) begin
                        e_ack = e_grant; e_err = e_grant; fin = 1'b1;
                    end
                end
                #3;
                chk("rnd_grant", o_grant, e_grant);
                chk("rnd_busy", o_busy, owner >= 0);
                chk("rnd_cs", o_cs, e_cs);
                chk("rnd_ack", o_m_ack, e_ack);
                chk("rnd_err", o_m_err, e_err);
                chk("rnd_mdat", o_m_dat, e_mdat);
                chk("rnd_addr", o_addr, e_addr);
                chk("rnd_dat", o_dat, e_dat);
                chk("rnd_we", o_we, e_we);
                last_ack = e_ack;

                if (owner < 0) begin
                    if (P0 && m_cs[0]) begin
                        owner = 0; elapsed = 1;
                    end else begin
                        for (int i = 1; i <= N && owner < 0; i++) begin
                            int k;
                            k = (rr_l + i) % N;
                            if (!(P0 && k == 0) && m_cs[k]) begin
                                owner = k; elapsed = 1; rr_l = k;
                            end
                        end
                    end
                end else if (fin) begin
                    owner = -1;
                end else begin
                    elapsed++;
                end
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
